axi_irq_mc: RTL
===============

AXI_IRQ_MC -- requirements
Module: axi_irq_mc

Interface
REQ-001 Parameter NUM_IRQ, default 8, range 1..32; number of interrupt sources.
REQ-002 Parameter SYNC_STAGES, default 2, range 2..3; synchronizer depth on irq_src.
REQ-003 Parameter IRQ_ACTIVE_HIGH, default 1; 1 means irq is active-high, 0 means irq is active-low.
REQ-004 Port ACLK, input, 1 bit; the only clock.
REQ-005 Port ARESET, input, 1 bit; one clock; reset is asynchronous and active-high.
REQ-006 Ports S_AXI_AW{ADDR[4:0],VALID} input, AWREADY output; S_AXI_W{DATA[31:0],STRB[3:0],VALID} input, WREADY output.
REQ-007 Ports S_AXI_B{RESP[1:0],VALID} output, BREADY input; S_AXI_AR{ADDR[4:0],VALID} input, ARREADY output.
REQ-008 Ports S_AXI_R{DATA[31:0],RESP[1:0],VALID} output, RREADY input.
REQ-009 Port irq_src, input, NUM_IRQ bits; asynchronous interrupt sources.
REQ-010 Port irq, output, 1 bit; registered interrupt request.

Function
REQ-011 Register map: 0x00 GIE[0], 0x04 IER, 0x08 ISR (RO raw status), 0x0C IAR (WO, write-1-to-clear ISR), 0x10 IPR (RO, ISR&IER), 0x14 MODE (1=edge, 0=level), 0x18 POL (1=active-high source), 0x1C VEC (RO).
REQ-012 VEC SHALL return the lowest-index set IPR bit, or 0xFFFFFFFF when IPR is zero.
REQ-013 Bits at or above NUM_IRQ SHALL read 0 and ignore writes; unmapped offsets read 0 and ignore writes; RESP is always OKAY (2'b00).
REQ-014 Write accept SHALL occur only when AWVALID and WVALID are both high and no B response is pending; AWREADY and WREADY pulse high for that one cycle.
REQ-015 BVALID SHALL rise the cycle after accept and hold until BREADY; no new write is accepted while BVALID is high.
REQ-016 Read accept SHALL occur when ARVALID is high and RVALID is low; RVALID rises next cycle with stable RDATA until RREADY.
REQ-017 WSTRB SHALL be honoured per byte for GIE, IER, MODE, POL, and IAR.
REQ-018 Each source SHALL pass through a SYNC_STAGES flop synchronizer; active level = synced XNOR POL bit.
REQ-019 Edge mode: ISR bit sets on an inactive->active transition of the active level; level mode: ISR bit sets every cycle the active level is present.
REQ-020 When an IAR clear and a set of the same bit occur in one cycle, set SHALL win.
REQ-021 irq SHALL be registered as GIE & |(ISR&IER) at the polarity set by IRQ_ACTIVE_HIGH; ISR latches regardless of IER and GIE.
REQ-022 Latency: irq asserts exactly SYNC_STAGES+2 ACLK cycles after the first edge sampling an active source; irq deasserts 2 cycles after the IAR write accept.
REQ-023 A MODE or POL write SHALL NOT itself set ISR bits; the edge-detect history updates with the new POL.

Reset
REQ-024 ARESET high SHALL immediately clear GIE, IER, ISR, MODE, the synchronizers, edge history, BVALID, RVALID, AWREADY, WREADY, ARREADY, and RDATA; POL SHALL be reset to all-ones; irq SHALL be inactive.
REQ-025 A transaction in flight when ARESET asserts SHALL be dropped with no response; the block accepts transactions from the first ACLK edge after deassertion.

Structure
REQ-026 Package axi_irq_mc_pkg SHALL hold the register offset constants, the RESP_OKAY constant, and the mode encoding.
REQ-027 Sub-module axi_irq_mc_sync (NUM_IRQ-wide synchronizer plus polarity and edge detect) SHALL be the only sub-module.

Verification
REQ-028 Scenario: write GIE=1, IER=0x01, MODE=0x01, pulse irq_src[0] for 1 cycle -> irq active 4 cycles later, IPR=0x1, VEC=0.
REQ-029 Scenario: IAR=0x1 write -> irq inactive 2 cycles after accept, IPR reads 0x0.
REQ-030 Scenario: level mode, POL[3]=0, irq_src[3] held low, IAR=0x8 -> ISR[3] reads 1 again; raising irq_src[3] then IAR=0x8 -> ISR[3]=0.
REQ-031 Scenario: sources 2 and 5 fire in the same cycle, IER=0x24 -> VEC=2; after IAR=0x4 -> VEC=5; after IAR=0x20 -> VEC=0xFFFFFFFF.
REQ-032 Scenario: IAR clear coincident with a new edge on that bit -> ISR bit stays 1; BREADY held low for 5 cycles -> BVALID holds and a second write is not accepted.
REQ-033 Scenario: ARESET asserted mid-read -> RVALID=0 immediately, POL=0xFFFFFFFF masked to NUM_IRQ bits, irq inactive.

Source files
------------

// File: rtl/axi_irq_mc_pkg.sv
// -----------------------------------------------------------------------------
// axi_irq_mc_pkg
// Shared constants for the AXI-Lite interrupt controller: register offsets,
// the AXI OKAY response code, the per-source trigger mode encoding, and a
// priority helper used to build the VEC register.
// -----------------------------------------------------------------------------
package axi_irq_mc_pkg;

  localparam logic [4:0] OFF_GIE  = 5'h00;
  localparam logic [4:0] OFF_IER  = 5'h04;
  localparam logic [4:0] OFF_ISR  = 5'h08;
  localparam logic [4:0] OFF_IAR  = 5'h0C;
  localparam logic [4:0] OFF_IPR  = 5'h10;
  localparam logic [4:0] OFF_MODE = 5'h14;
  localparam logic [4:0] OFF_POL  = 5'h18;
  localparam logic [4:0] OFF_VEC  = 5'h1C;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } irq_mode_e;

  // Index of the lowest set bit, or all-ones when nothing is pending.
  function automatic logic [31:0] lowest_set(input logic [31:0] v);
    logic [31:0] res;
    logic        found;
    res   = '1;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i] && !found) begin
        res   = i;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_irq_mc_sync.sv
// -----------------------------------------------------------------------------
// axi_irq_mc_sync
// Per-source synchronizer, polarity normalisation and trigger detection.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_src        : raw asynchronous interrupt sources
//   i_pol        : current polarity (1 = active-high source)
//   i_pol_next   : polarity value being loaded this cycle
//   i_mode       : trigger mode per source (MODE_EDGE / MODE_LEVEL)
//   o_set        : one-cycle ISR set request per source
// -----------------------------------------------------------------------------
module axi_irq_mc_sync
  import axi_irq_mc_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_IRQ-1:0] i_src,
  input  logic [NUM_IRQ-1:0] i_pol,
  input  logic [NUM_IRQ-1:0] i_pol_next,
  input  logic [NUM_IRQ-1:0] i_mode,
  output logic [NUM_IRQ-1:0] o_set
);

  logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [NUM_IRQ-1:0] r_hist;
  logic [NUM_IRQ-1:0] w_act;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= i_src;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      // History is taken with the polarity that will be in force next cycle,
      // so a POL write never looks like an inactive->active transition.
      r_hist <= ~(r_sync[SYNC_STAGES-1] ^ i_pol_next);
    end
  end

  always_comb begin
    w_act = ~(r_sync[SYNC_STAGES-1] ^ i_pol);
    o_set = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (i_mode[i] == MODE_EDGE) o_set[i] = w_act[i] & ~r_hist[i];
      else                        o_set[i] = w_act[i];
    end
  end

endmodule

// File: rtl/axi_irq_mc.sv
// -----------------------------------------------------------------------------
// axi_irq_mc
// AXI4-Lite interrupt controller with per-source edge/level mode, polarity,
// enable, write-1-to-clear acknowledge and a lowest-index priority vector.
//   ACLK, ARESET   : clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*: write address/data/response channels (5-bit address)
//   S_AXI_AR*/R*   : read address/data channels
//   irq_src        : NUM_IRQ asynchronous interrupt sources
//   irq            : registered interrupt request, polarity IRQ_ACTIVE_HIGH
// Registers: 0x00 GIE, 0x04 IER, 0x08 ISR, 0x0C IAR, 0x10 IPR, 0x14 MODE,
//            0x18 POL, 0x1C VEC.
// -----------------------------------------------------------------------------
module axi_irq_mc
  import axi_irq_mc_pkg::*;
#(
  parameter int unsigned NUM_IRQ         = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int          IRQ_ACTIVE_HIGH = 1
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [4:0]         S_AXI_AWADDR,
  input  logic               S_AXI_AWVALID,
  output logic               S_AXI_AWREADY,
  input  logic [31:0]        S_AXI_WDATA,
  input  logic [3:0]         S_AXI_WSTRB,
  input  logic               S_AXI_WVALID,
  output logic               S_AXI_WREADY,
  output logic [1:0]         S_AXI_BRESP,
  output logic               S_AXI_BVALID,
  input  logic               S_AXI_BREADY,
  input  logic [4:0]         S_AXI_ARADDR,
  input  logic               S_AXI_ARVALID,
  output logic               S_AXI_ARREADY,
  output logic [31:0]        S_AXI_RDATA,
  output logic [1:0]         S_AXI_RRESP,
  output logic               S_AXI_RVALID,
  input  logic               S_AXI_RREADY,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq
);

  localparam logic [31:0] IRQ_MASK =
    (NUM_IRQ >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << NUM_IRQ) - 64'd1);
  localparam logic IRQ_IDLE = (IRQ_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  logic        r_awready, r_wready, r_bvalid;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_arready, r_rvalid;
  logic [4:0]  r_raddr;
  logic [31:0] r_rdata;
  logic        r_gie;
  logic [31:0] r_ier, r_isr, r_mode, r_pol;
  logic        r_irq;

  logic               w_wr_start, w_wr_commit, w_rd_start, w_irq_any;
  logic [31:0]        w_bmask, w_wbits, w_iar_clr, w_pol_next, w_set32, w_rmux;
  logic [NUM_IRQ-1:0] w_set;

  // Write: the request is captured on the accept edge, ready is shown for one
  // cycle, and the register update lands on the edge that completes it.
  assign w_wr_start  = S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
  assign w_wr_commit = r_awready;
  assign w_rd_start  = S_AXI_ARVALID & ~r_rvalid & ~r_arready;

  assign w_bmask = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  assign w_wbits = r_wdata & w_bmask & IRQ_MASK;

  assign w_iar_clr  = (w_wr_commit && r_waddr == OFF_IAR) ? w_wbits : '0;
  assign w_pol_next = (w_wr_commit && r_waddr == OFF_POL)
                      ? ((r_pol & ~w_bmask) | w_wbits) : r_pol;

  assign w_irq_any = r_gie & (|(r_isr & r_ier));

  axi_irq_mc_sync #(
    .NUM_IRQ    (NUM_IRQ),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_src     (irq_src),
    .i_pol     (r_pol[NUM_IRQ-1:0]),
    .i_pol_next(w_pol_next[NUM_IRQ-1:0]),
    .i_mode    (r_mode[NUM_IRQ-1:0]),
    .o_set     (w_set)
  );

  always_comb begin
    w_set32 = '0;
    w_set32[NUM_IRQ-1:0] = w_set;
  end

  always_comb begin
    w_rmux = '0;
    case (r_raddr)
      OFF_GIE:  w_rmux = {31'd0, r_gie};
      OFF_IER:  w_rmux = r_ier;
      OFF_ISR:  w_rmux = r_isr;
      OFF_IPR:  w_rmux = r_isr & r_ier;
      OFF_MODE: w_rmux = r_mode;
      OFF_POL:  w_rmux = r_pol;
      OFF_VEC:  w_rmux = lowest_set(r_isr & r_ier);
      default:  w_rmux = '0;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_wr_start) begin
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_waddr   <= S_AXI_AWADDR;
      r_wdata   <= S_AXI_WDATA;
      r_wstrb   <= S_AXI_WSTRB;
    end else if (r_awready) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b1;
    end else if (r_bvalid && S_AXI_BREADY) begin
      r_bvalid  <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_raddr   <= '0;
      r_rdata   <= '0;
    end else if (w_rd_start) begin
      r_arready <= 1'b1;
      r_raddr   <= S_AXI_ARADDR;
    end else if (r_arready) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b1;
      r_rdata   <= w_rmux;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid  <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_gie  <= 1'b0;
      r_ier  <= '0;
      r_isr  <= '0;
      r_mode <= '0;
      r_pol  <= IRQ_MASK;
      r_irq  <= IRQ_IDLE;
    end else begin
      if (w_wr_commit) begin
        case (r_waddr)
          OFF_GIE:  if (r_wstrb[0]) r_gie <= r_wdata[0];
          OFF_IER:  r_ier  <= (r_ier  & ~w_bmask) | w_wbits;
          OFF_MODE: r_mode <= (r_mode & ~w_bmask) | w_wbits;
          default:  ;
        endcase
      end
      r_pol <= w_pol_next;
      // A set arriving in the same cycle as an acknowledge takes precedence.
      r_isr <= ((r_isr & ~w_iar_clr) | w_set32) & IRQ_MASK;
      r_irq <= (IRQ_ACTIVE_HIGH != 0) ? w_irq_any : ~w_irq_any;
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign irq           = r_irq;

endmodule
